// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams and the UART Tx write port shared by uart_tx_arbiter.
// The master modport is the arbiter's view; slave is the requester/UART side.
interface uart_tx_arbiter_if #(
  parameter int N = 2
);
  // Handshake: a requester holds req_valid/req_data/req_last stable until
  // req_ready[i] pulses for one cycle. That pulse is a registered acknowledge
  // of the byte sampled on the previous edge. uart_ready is a level; a data
  // write is only issued on an edge where it is high.
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;

  logic           uart_ready;
  logic [31:0]    uart_addr;
  logic           uart_wr_en;
  logic [7:0]     uart_raw_data;
  logic [13:0]    uart_baud_divisor;
  logic           uart_tx_en;
  logic           uart_two_stop;
  logic           uart_odd_parity;

  modport master (
    input  req_valid, req_data, req_last, uart_ready,
    output req_ready, grant, uart_addr, uart_wr_en, uart_raw_data,
           uart_baud_divisor, uart_tx_en, uart_two_stop, uart_odd_parity
  );

  modport slave (
    output req_valid, req_data, req_last, uart_ready,
    input  req_ready, grant, uart_addr, uart_wr_en, uart_raw_data,
           uart_baud_divisor, uart_tx_en, uart_two_stop, uart_odd_parity
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Programs the UART baud/control registers, then shares its Tx data port among
// N requesters round-robin, one message (or MAX_BURST bytes) per grant.
module uart_tx_arbiter #(
  parameter int N         = 2,
  parameter int MAX_BURST = 16,
  parameter int WR_GAP    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [13:0]         cfg_baud,
  input  logic                cfg_two_stop,
  input  logic                cfg_odd_parity,
  input  logic                cfg_update,
  uart_tx_arbiter_if.master   bus,
  output logic                busy,
  output logic [2:0]          o_dbg_state
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = $clog2(WR_GAP + 1);

  typedef enum logic [2:0] {
    CFG_BAUD = 3'd0,
    CFG_CTRL = 3'd1,
    ARB      = 3'd2,
    XFER     = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t          r_state, w_state;
  logic [IW-1:0]   r_ptr, w_ptr;
  logic [IW-1:0]   r_gidx, w_gidx;
  logic            r_pending, w_pending;
  logic [7:0]      r_burst, w_burst;
  logic [GW-1:0]   r_gap, w_gap;
  logic            r_last, w_last;
  logic            r_wr_en, w_wr_en;
  logic [31:0]     r_addr, w_addr;
  logic [7:0]      r_data, w_data;
  logic [13:0]     r_baud, w_baud;
  logic            r_tx_en, w_tx_en;
  logic            r_two_stop, w_two_stop;
  logic            r_odd, w_odd;
  logic [N-1:0]    r_req_ready, w_req_ready;
  logic [N-1:0]    r_grant, w_grant;
  logic            r_busy, w_busy;

  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic [IW-1:0]   w_idx;

  // First valid requester at or above the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % N);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_state     = r_state;
    w_ptr       = r_ptr;
    w_gidx      = r_gidx;
    w_pending   = r_pending | cfg_update;
    w_burst     = r_burst;
    w_gap       = r_gap;
    w_last      = r_last;
    w_wr_en     = 1'b0;
    w_addr      = r_addr;
    w_data      = r_data;
    w_baud      = r_baud;
    w_tx_en     = r_tx_en;
    w_two_stop  = r_two_stop;
    w_odd       = r_odd;
    w_req_ready = '0;
    w_grant     = r_grant;

    case (r_state)
      CFG_BAUD: begin
        if (cfg_baud != 14'd0) begin
          w_wr_en = 1'b1;
          w_addr  = 32'hC;
          w_baud  = cfg_baud;
          w_state = CFG_CTRL;
        end
      end
      CFG_CTRL: begin
        w_wr_en    = 1'b1;
        w_addr     = 32'h4;
        w_tx_en    = 1'b1;
        w_two_stop = cfg_two_stop;
        w_odd      = cfg_odd_parity;
        // An update arriving now must survive the clear.
        w_pending  = cfg_update;
        w_state    = ARB;
      end
      ARB: begin
        w_grant = '0;
        if (r_pending) begin
          w_state = CFG_BAUD;
        end else if (w_found) begin
          w_grant[w_pick] = 1'b1;
          w_gidx          = w_pick;
          w_burst         = 8'd0;
          w_state         = XFER;
        end
      end
      XFER: begin
        if (bus.req_valid[r_gidx] && bus.uart_ready) begin
          w_req_ready[r_gidx] = 1'b1;
          w_wr_en             = 1'b1;
          w_addr              = 32'h0;
          w_data              = bus.req_data[8*r_gidx +: 8];
          w_burst             = r_burst + 8'd1;
          w_last              = bus.req_last[r_gidx];
          w_gap               = '0;
          w_state             = GAP;
        end
      end
      GAP: begin
        if (r_gap == GW'(WR_GAP - 1)) begin
          if (r_last || (r_burst == 8'(MAX_BURST))) begin
            w_ptr   = (r_gidx == IW'(N - 1)) ? '0 : r_gidx + 1'b1;
            w_grant = '0;
            w_state = ARB;
          end else begin
            w_state = XFER;
          end
        end else begin
          w_gap = r_gap + 1'b1;
        end
      end
      default: w_state = CFG_BAUD;
    endcase

    w_busy = (w_state != ARB);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= CFG_BAUD;
      r_ptr       <= '0;
      r_gidx      <= '0;
      r_pending   <= 1'b1;
      r_burst     <= 8'd0;
      r_gap       <= '0;
      r_last      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_addr      <= 32'h0;
      r_data      <= 8'h0;
      r_baud      <= 14'h0;
      r_tx_en     <= 1'b0;
      r_two_stop  <= 1'b0;
      r_odd       <= 1'b0;
      r_req_ready <= '0;
      r_grant     <= '0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_state;
      r_ptr       <= w_ptr;
      r_gidx      <= w_gidx;
      r_pending   <= w_pending;
      r_burst     <= w_burst;
      r_gap       <= w_gap;
      r_last      <= w_last;
      r_wr_en     <= w_wr_en;
      r_addr      <= w_addr;
      r_data      <= w_data;
      r_baud      <= w_baud;
      r_tx_en     <= w_tx_en;
      r_two_stop  <= w_two_stop;
      r_odd       <= w_odd;
      r_req_ready <= w_req_ready;
      r_grant     <= w_grant;
      r_busy      <= w_busy;
    end
  end

  assign bus.uart_wr_en        = r_wr_en;
  assign bus.uart_addr         = r_addr;
  assign bus.uart_raw_data     = r_data;
  assign bus.uart_baud_divisor = r_baud;
  assign bus.uart_tx_en        = r_tx_en;
  assign bus.uart_two_stop     = r_two_stop;
  assign bus.uart_odd_parity   = r_odd;
  assign bus.req_ready         = r_req_ready;
  assign bus.grant             = r_grant;
  assign busy                  = r_busy;
  assign o_dbg_state           = r_state;
endmodule
